// File: rtl/mcse_ahb_pkg.sv
// mcse_ahb_pkg
// Shared AHB-Lite encodings and the requester state type used by the MCSE
// payload-bus to AHB requester bridge.
//   htrans_e     : AHB HTRANS encodings
//   HBURST_INCR8 : 8-beat incrementing burst
//   HSIZE_WORD   : 32-bit transfer size
//   HPROT_DATA_PRIV : data access, privileged
//   HRESP_OKAY / HRESP_ERROR : slave response codes
//   req_state_e  : requester state machine states
package mcse_ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic [2:0] HBURST_INCR8    = 3'b101;
    localparam logic [2:0] HSIZE_WORD      = 3'b010;
    localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        REQ_IDLE  = 3'd0,
        REQ_ADDR  = 3'd1,
        REQ_BURST = 3'd2,
        REQ_LAST  = 3'd3,
        REQ_DONE  = 3'd4,
        REQ_ERR   = 3'd5
    } req_state_e;

endpackage

// File: rtl/mcse_ahb_requester.sv
// mcse_ahb_requester
// Bridges one MCSE payload-bus request into a single INCR8 word burst on an
// AHB-Lite requester port. Address and data phases overlap, wait states are
// honoured, and an ERROR response aborts the burst after the two-cycle
// response. Completion is a single-cycle bus_done pulse.
//
// Handshake: a request is taken only when the FSM is idle and bus_go is high
// on a rising clk edge; bus_go is ignored at all other times. An AHB address
// or data phase completes on a rising edge with I_hready high; while I_hready
// is low every AHB output and both beat counters hold.
//
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   bus_go            : request strobe (sampled in idle only)
//   bus_addr          : payload byte address (aligned down to 32 bytes)
//   bus_write         : write payload, beat n = bits [32n+31:32n]
//   bus_RW            : 1 = write, 0 = read
//   bus_done          : one-cycle completion pulse
//   bus_rdData        : assembled read payload, valid at bus_done
//   bus_err           : error flag of the last request
//   I_hrdata/I_hready/I_hresp : AHB response inputs
//   O_h*              : registered AHB requester outputs
//   dbg_state_o       : current requester state (req_state_e encoding)
module mcse_ahb_requester
    import mcse_ahb_pkg::*;
#(
    parameter int pAHB_DATA_WIDTH    = 32,
    parameter int pAHB_ADDR_WIDTH    = 32,
    parameter int pPAYLOAD_SIZE_BITS = 256,
    parameter int pAHB_HRESP_WIDTH   = 2,
    parameter int pAHB_BURST_WIDTH   = 3,
    parameter int pAHB_PROT_WIDTH    = 4,
    parameter int pAHB_SIZE_WIDTH    = 3,
    parameter int pAHB_TRANS_WIDTH   = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          bus_go,
    input  logic [pAHB_ADDR_WIDTH-1:0]    bus_addr,
    input  logic [pPAYLOAD_SIZE_BITS-1:0] bus_write,
    input  logic                          bus_RW,
    output logic                          bus_done,
    output logic [pPAYLOAD_SIZE_BITS-1:0] bus_rdData,
    output logic                          bus_err,
    input  logic [pAHB_DATA_WIDTH-1:0]    I_hrdata,
    input  logic                          I_hready,
    input  logic [pAHB_HRESP_WIDTH-1:0]   I_hresp,
    output logic [pAHB_ADDR_WIDTH-1:0]    O_haddr,
    output logic [pAHB_BURST_WIDTH-1:0]   O_hburst,
    output logic                          O_hmastlock,
    output logic [pAHB_PROT_WIDTH-1:0]    O_hprot,
    output logic                          O_hnonsec,
    output logic [pAHB_SIZE_WIDTH-1:0]    O_hsize,
    output logic [pAHB_TRANS_WIDTH-1:0]   O_htrans,
    output logic [pAHB_DATA_WIDTH-1:0]    O_hwdata,
    output logic                          O_hwrite,
    output logic [2:0]                    dbg_state_o
);

    localparam int BEATS          = pPAYLOAD_SIZE_BITS / pAHB_DATA_WIDTH;
    localparam int CNT_W          = $clog2(BEATS);
    localparam int BYTES_PER_BEAT = pAHB_DATA_WIDTH / 8;
    localparam int BEAT_SHIFT     = $clog2(BYTES_PER_BEAT);

    localparam logic [CNT_W-1:0]           LAST_BEAT  = CNT_W'(BEATS - 1);
    localparam logic [pAHB_ADDR_WIDTH-1:0] ALIGN_MASK =
        pAHB_ADDR_WIDTH'(BEATS * BYTES_PER_BEAT - 1);

    // Burst control fields never change, so they are tied off.
    assign O_hburst    = pAHB_BURST_WIDTH'(HBURST_INCR8);
    assign O_hsize     = pAHB_SIZE_WIDTH'(HSIZE_WORD);
    assign O_hprot     = pAHB_PROT_WIDTH'(HPROT_DATA_PRIV);
    assign O_hnonsec   = 1'b0;
    assign O_hmastlock = 1'b0;

    req_state_e                    state_q,   state_d;
    logic [CNT_W-1:0]              acnt_q,    acnt_d;    // beat whose address is on the bus
    logic [CNT_W-1:0]              dcnt_q,    dcnt_d;    // beat whose data phase is active
    logic [pAHB_ADDR_WIDTH-1:0]    base_q,    base_d;
    logic [pPAYLOAD_SIZE_BITS-1:0] payload_q, payload_d;
    logic                          rw_q,      rw_d;
    logic [pAHB_ADDR_WIDTH-1:0]    haddr_q,   haddr_d;
    htrans_e                       htrans_q,  htrans_d;
    logic [pAHB_DATA_WIDTH-1:0]    hwdata_q,  hwdata_d;
    logic                          hwrite_q,  hwrite_d;
    logic                          done_q,    done_d;
    logic                          err_q,     err_d;
    logic [pPAYLOAD_SIZE_BITS-1:0] rdata_q,   rdata_d;

    logic [CNT_W-1:0]              acnt_nx;
    logic [pAHB_ADDR_WIDTH-1:0]    aligned_addr;
    logic                          resp_err;

    assign acnt_nx      = acnt_q + CNT_W'(1);
    assign aligned_addr = bus_addr & ~ALIGN_MASK;
    // Anything other than OKAY is handled as ERROR.
    assign resp_err     = (I_hresp != pAHB_HRESP_WIDTH'(HRESP_OKAY));

    always_comb begin
        state_d   = state_q;
        acnt_d    = acnt_q;
        dcnt_d    = dcnt_q;
        base_d    = base_q;
        payload_d = payload_q;
        rw_d      = rw_q;
        haddr_d   = haddr_q;
        htrans_d  = htrans_q;
        hwdata_d  = hwdata_q;
        hwrite_d  = hwrite_q;
        done_d    = 1'b0;
        err_d     = err_q;
        rdata_d   = rdata_q;

        case (state_q)
            REQ_IDLE: begin
                if (bus_go) begin
                    state_d   = REQ_ADDR;
                    base_d    = aligned_addr;
                    payload_d = bus_write;
                    rw_d      = bus_RW;
                    err_d     = 1'b0;
                    rdata_d   = '0;
                    haddr_d   = aligned_addr;
                    htrans_d  = HTRANS_NONSEQ;
                    hwrite_d  = bus_RW;
                    acnt_d    = '0;
                    dcnt_d    = '0;
                end
            end

            REQ_ADDR: begin
                // Beat 0 address accepted: its data phase opens and the
                // beat 1 address goes out in the same cycle.
                if (I_hready) begin
                    state_d  = REQ_BURST;
                    dcnt_d   = acnt_q;
                    acnt_d   = acnt_nx;
                    hwdata_d = payload_q[int'(acnt_q)*pAHB_DATA_WIDTH +: pAHB_DATA_WIDTH];
                    haddr_d  = base_q + (pAHB_ADDR_WIDTH'(acnt_nx) << BEAT_SHIFT);
                    htrans_d = HTRANS_SEQ;
                end
            end

            REQ_BURST: begin
                if (!I_hready) begin
                    // First cycle of a two-cycle error response: drop the
                    // pending address so the second cycle shows IDLE.
                    if (resp_err) begin
                        state_d  = REQ_ERR;
                        htrans_d = HTRANS_IDLE;
                    end
                end else begin
                    if (!rw_q) begin
                        rdata_d[int'(dcnt_q)*pAHB_DATA_WIDTH +: pAHB_DATA_WIDTH] = I_hrdata;
                    end
                    dcnt_d   = acnt_q;
                    hwdata_d = payload_q[int'(acnt_q)*pAHB_DATA_WIDTH +: pAHB_DATA_WIDTH];
                    if (acnt_q == LAST_BEAT) begin
                        state_d  = REQ_LAST;
                        htrans_d = HTRANS_IDLE;
                    end else begin
                        acnt_d   = acnt_nx;
                        haddr_d  = base_q + (pAHB_ADDR_WIDTH'(acnt_nx) << BEAT_SHIFT);
                        htrans_d = HTRANS_SEQ;
                    end
                end
            end

            REQ_LAST: begin
                if (!I_hready) begin
                    if (resp_err) begin
                        state_d  = REQ_ERR;
                        htrans_d = HTRANS_IDLE;
                    end
                end else begin
                    if (!rw_q) begin
                        rdata_d[int'(dcnt_q)*pAHB_DATA_WIDTH +: pAHB_DATA_WIDTH] = I_hrdata;
                    end
                    state_d = REQ_DONE;
                    done_d  = 1'b1;
                end
            end

            REQ_ERR: begin
                // Second error cycle completes with I_hready high.
                if (I_hready) begin
                    state_d = REQ_DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end

            REQ_DONE: begin
                state_d = REQ_IDLE;
            end

            default: begin
                state_d  = REQ_IDLE;
                htrans_d = HTRANS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= REQ_IDLE;
            acnt_q    <= '0;
            dcnt_q    <= '0;
            base_q    <= '0;
            payload_q <= '0;
            rw_q      <= 1'b0;
            haddr_q   <= '0;
            htrans_q  <= HTRANS_IDLE;
            hwdata_q  <= '0;
            hwrite_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            acnt_q    <= acnt_d;
            dcnt_q    <= dcnt_d;
            base_q    <= base_d;
            payload_q <= payload_d;
            rw_q      <= rw_d;
            haddr_q   <= haddr_d;
            htrans_q  <= htrans_d;
            hwdata_q  <= hwdata_d;
            hwrite_q  <= hwrite_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
        end
    end

    assign O_haddr     = haddr_q;
    assign O_htrans    = pAHB_TRANS_WIDTH'(htrans_q);
    assign O_hwdata    = hwdata_q;
    assign O_hwrite    = hwrite_q;
    assign bus_done    = done_q;
    assign bus_err     = err_q;
    assign bus_rdData  = rdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mcse_ahb_requester.sv
// tb_mcse_ahb_requester
// Self-checking bench for mcse_ahb_requester. A protocol-level AHB slave
// model answers transfers (configurable wait states per beat, optional
// two-cycle ERROR on one beat, read data 0x11*beat) and logs every accepted
// address and completed write beat. Each test builds its expectations from
// the burst rules (aligned base + 4*i, 10-cycle zero-wait latency plus waits).
`timescale 1ns/1ps
module tb_mcse_ahb_requester;
    import mcse_ahb_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         bus_go = 1'b0;
    logic [31:0]  bus_addr = '0;
    logic [255:0] bus_write = '0;
    logic         bus_RW = 1'b0;
    logic         bus_done;
    logic [255:0] bus_rdData;
    logic         bus_err;
    logic [31:0]  I_hrdata = '0;
    logic         I_hready = 1'b1;
    logic [1:0]   I_hresp = 2'b00;
    logic [31:0]  O_haddr;
    logic [2:0]   O_hburst;
    logic         O_hmastlock;
    logic [3:0]   O_hprot;
    logic         O_hnonsec;
    logic [2:0]   O_hsize;
    logic [1:0]   O_htrans;
    logic [31:0]  O_hwdata;
    logic         O_hwrite;
    logic [2:0]   dbg_state;

    mcse_ahb_requester dut (
        .clk(clk), .rst_n(rst_n), .bus_go(bus_go), .bus_addr(bus_addr),
        .bus_write(bus_write), .bus_RW(bus_RW), .bus_done(bus_done),
        .bus_rdData(bus_rdData), .bus_err(bus_err), .I_hrdata(I_hrdata),
        .I_hready(I_hready), .I_hresp(I_hresp), .O_haddr(O_haddr),
        .O_hburst(O_hburst), .O_hmastlock(O_hmastlock), .O_hprot(O_hprot),
        .O_hnonsec(O_hnonsec), .O_hsize(O_hsize), .O_htrans(O_htrans),
        .O_hwdata(O_hwdata), .O_hwrite(O_hwrite), .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset / cycle counter ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Reset image: {htrans, haddr, hwdata, hwrite, hburst, hsize, hprot,
    //               hnonsec, hmastlock, bus_done, bus_err}
    localparam logic [81:0] RST_VEC = {2'b00, 32'h0, 32'h0, 1'b0, 3'b101,
                                       3'b010, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0};

    // ---------------- slave model ----------------
    int          wait_cfg [8];
    int          err_beat = -1;
    int          burst_id = 0;
    int          seen_id  = 0;
    logic [31:0] acc_addr_q [$];
    logic [1:0]  acc_trans_q [$];
    int          acc_cyc_q [$];
    logic [31:0] wdata_q [$];
    int          wcyc_q [$];
    int          stall_viol = 0;
    int          err_seen = 0;
    logic [1:0]  err_htrans = 2'b11;
    int          done_cnt = 0;
    bit          dp_valid = 0;
    bit          dp_write = 0;
    int          dp_beat = 0;
    int          wait_left = 0;
    bit          err_pend = 0;
    bit          prev_wait = 0;
    logic [31:0] prev_haddr = '0;
    logic [1:0]  prev_htrans = '0;
    logic [31:0] prev_hwdata = '0;

    always @(negedge clk) begin
        bit          rdy;
        logic [1:0]  resp;
        logic [31:0] rd;
        if (burst_id != seen_id) begin
            seen_id = burst_id;
            acc_addr_q.delete(); acc_trans_q.delete(); acc_cyc_q.delete();
            wdata_q.delete(); wcyc_q.delete();
            stall_viol = 0; err_seen = 0; err_htrans = 2'b11;
        end
        if (bus_done === 1'b1) done_cnt++;
        if (!rst_n) begin
            dp_valid = 0; err_pend = 0; prev_wait = 0;
            I_hready = 1'b1; I_hresp = HRESP_OKAY; I_hrdata = '0;
        end else begin
            if (prev_wait && (O_haddr !== prev_haddr || O_htrans !== prev_htrans ||
                              O_hwdata !== prev_hwdata))
                stall_viol++;
            rdy = 1'b1; resp = HRESP_OKAY; rd = '0;
            if (dp_valid) begin
                rd = 32'h11 * dp_beat;
                if (err_pend) begin
                    resp = HRESP_ERROR; err_pend = 0; err_seen = 1; err_htrans = O_htrans;
                end else if (dp_beat == err_beat) begin
                    rdy = 1'b0; resp = HRESP_ERROR; err_pend = 1;
                end else if (wait_left > 0) begin
                    rdy = 1'b0; wait_left--;
                end else if (dp_write) begin
                    wdata_q.push_back(O_hwdata); wcyc_q.push_back(cyc);
                end
            end
            prev_wait = !rdy && (resp == HRESP_OKAY);
            prev_haddr = O_haddr; prev_htrans = O_htrans; prev_hwdata = O_hwdata;
            if (rdy) begin
                if (O_htrans == HTRANS_NONSEQ || O_htrans == HTRANS_SEQ) begin
                    acc_addr_q.push_back(O_haddr); acc_trans_q.push_back(O_htrans);
                    acc_cyc_q.push_back(cyc);
                    dp_valid = 1; dp_write = O_hwrite;
                    dp_beat = int'((O_haddr >> 2) & 32'h7);
                    wait_left = wait_cfg[dp_beat];
                end else begin
                    dp_valid = 0;
                end
            end
            I_hready = rdy; I_hresp = resp; I_hrdata = rd;
        end
    end

    // ---------------- driver ----------------
    // Called at negedge+1; raises bus_go for the cycle it is sampled in
    // (cycle 0) and waits up to 60 cycles for bus_done.
    task automatic start_and_wait(input logic [31:0] a, input logic rw,
                                  input logic [255:0] pl, input bit hold_go,
                                  output int c0, output int done_rel);
        burst_id++;
        c0 = cyc;
        bus_addr = a; bus_RW = rw; bus_write = pl; bus_go = 1'b1;
        done_rel = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk); #1;
            if (!hold_go) bus_go = 1'b0;
            if (bus_done === 1'b1) begin
                done_rel = cyc - c0;
                break;
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; bus_go = 1'b0;
        idle_cycles(3);
        n_checks++; if (O_htrans !== 2'b00) begin n_fail++; $display("FAIL reset_htrans got %h want 0", O_htrans); end
        n_checks++; if (O_haddr !== 32'h0) begin n_fail++; $display("FAIL reset_haddr got %h want 0", O_haddr); end
        n_checks++; if (O_hwdata !== 32'h0) begin n_fail++; $display("FAIL reset_hwdata got %h want 0", O_hwdata); end
        n_checks++; if (O_hwrite !== 1'b0) begin n_fail++; $display("FAIL reset_hwrite got %b want 0", O_hwrite); end
        n_checks++; if (O_hburst !== 3'b101) begin n_fail++; $display("FAIL reset_hburst got %b want 101", O_hburst); end
        n_checks++; if (O_hsize !== 3'b010) begin n_fail++; $display("FAIL reset_hsize got %b want 010", O_hsize); end
        n_checks++; if (O_hprot !== 4'b0011) begin n_fail++; $display("FAIL reset_hprot got %b want 0011", O_hprot); end
        n_checks++; if ({O_hnonsec, O_hmastlock} !== 2'b00) begin n_fail++; $display("FAIL reset_nonsec_lock got %b want 00", {O_hnonsec, O_hmastlock}); end
        n_checks++; if (bus_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus_done); end
        n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", bus_err); end
        n_checks++; if (bus_rdData !== 256'h0) begin n_fail++; $display("FAIL reset_rddata got %h want 0", bus_rdData); end
        rst_n = 1'b1;
        idle_cycles(2);
    endtask

    task automatic test_write_zero_wait();
        logic [255:0] pl;
        logic [31:0]  exp_q [$];
        logic [31:0]  obs;
        int c0, d;
        for (int i = 0; i < 8; i++) begin pl[32*i +: 32] = 32'hA0 + i; wait_cfg[i] = 0; end
        err_beat = -1;
        start_and_wait(32'h1000_0004, 1'b1, pl, 1'b0, c0, d);
        n_checks++; if (d !== 10) begin n_fail++; $display("FAIL wr_done_cycle got %0d want 10", d); end
        n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL wr_err got %b want 0", bus_err); end
        n_checks++; if (acc_addr_q.size() !== 8) begin n_fail++; $display("FAIL wr_addr_count got %0d want 8", acc_addr_q.size()); end
        for (int i = 0; i < 8; i++) exp_q.push_back(32'h1000_0000 + 32'(4 * i));
        for (int i = 0; i < 8; i++) begin
            obs = (i < acc_addr_q.size()) ? acc_addr_q[i] : 32'hxxxx_xxxx;
            n_checks++; if (obs !== exp_q[i]) begin n_fail++; $display("FAIL wr_addr[%0d] got %h want %h", i, obs, exp_q[i]); end
            if (i < acc_trans_q.size()) begin
                n_checks++;
                if (acc_trans_q[i] !== ((i == 0) ? 2'b10 : 2'b11) || acc_cyc_q[i] - c0 !== 1 + i) begin
                    n_fail++; $display("FAIL wr_trans[%0d] got %b@%0d want %b@%0d", i, acc_trans_q[i], acc_cyc_q[i] - c0, (i == 0) ? 2'b10 : 2'b11, 1 + i);
                end
            end
            obs = (i < wdata_q.size()) ? wdata_q[i] : 32'hxxxx_xxxx;
            n_checks++; if (obs !== 32'hA0 + i) begin n_fail++; $display("FAIL wr_data[%0d] got %h want %h", i, obs, 32'hA0 + i); end
            if (i < wcyc_q.size()) begin
                n_checks++; if (wcyc_q[i] - c0 !== 2 + i) begin n_fail++; $display("FAIL wr_data_cycle[%0d] got %0d want %0d", i, wcyc_q[i] - c0, 2 + i); end
            end
        end
        idle_cycles(1);
        n_checks++; if (bus_done !== 1'b0) begin n_fail++; $display("FAIL wr_done_width got %b want 0", bus_done); end
        idle_cycles(1);
    endtask

    task automatic test_read_waits();
        logic [255:0] exp_rd;
        logic [31:0]  a, obs;
        int c0, d;
        for (int i = 0; i < 8; i++) begin wait_cfg[i] = 0; exp_rd[32*i +: 32] = 32'h11 * i; end
        wait_cfg[0] = 2; wait_cfg[5] = 2; err_beat = -1;
        a = $urandom;
        start_and_wait(a, 1'b0, {8{$urandom}}, 1'b0, c0, d);
        n_checks++; if (d !== 14) begin n_fail++; $display("FAIL rd_done_cycle got %0d want 14", d); end
        n_checks++; if (bus_rdData !== exp_rd) begin n_fail++; $display("FAIL rd_data got %h want %h", bus_rdData, exp_rd); end
        n_checks++; if (stall_viol !== 0) begin n_fail++; $display("FAIL rd_stall_hold got %0d changes want 0", stall_viol); end
        n_checks++; if (wdata_q.size() !== 0) begin n_fail++; $display("FAIL rd_is_read got %0d write beats want 0", wdata_q.size()); end
        for (int i = 0; i < 8; i++) begin
            obs = (i < acc_addr_q.size()) ? acc_addr_q[i] : 32'hxxxx_xxxx;
            n_checks++; if (obs !== (a & 32'hFFFF_FFE0) + 32'(4 * i)) begin n_fail++; $display("FAIL rd_addr[%0d] got %h want %h", i, obs, (a & 32'hFFFF_FFE0) + 32'(4 * i)); end
        end
        for (int i = 0; i < 8; i++) wait_cfg[i] = 0;
        idle_cycles(2);
    endtask

    task automatic test_random();
        logic [255:0] pl, exp_rd;
        logic [31:0]  a;
        logic         rw;
        int c0, d, waits;
        for (int it = 0; it < 6; it++) begin
            a = $urandom; rw = 1'(($urandom_range(0, 1))); waits = 0;
            for (int i = 0; i < 8; i++) begin
                pl[32*i +: 32] = $urandom;
                exp_rd[32*i +: 32] = 32'h11 * i;
                wait_cfg[i] = $urandom_range(0, 2);
                waits += wait_cfg[i];
            end
            start_and_wait(a, rw, pl, 1'b0, c0, d);
            n_checks++; if (d !== 10 + waits) begin n_fail++; $display("FAIL rnd%0d_done_cycle got %0d want %0d", it, d, 10 + waits); end
            n_checks++; if (stall_viol !== 0) begin n_fail++; $display("FAIL rnd%0d_stall_hold got %0d want 0", it, stall_viol); end
            n_checks++; if (acc_addr_q.size() !== 8 || acc_addr_q[0] !== (a & 32'hFFFF_FFE0) || acc_addr_q[7] !== (a & 32'hFFFF_FFE0) + 32'h1C) begin
                n_fail++; $display("FAIL rnd%0d_addr got n=%0d first=%h want n=8 base=%h", it, acc_addr_q.size(), (acc_addr_q.size() > 0) ? acc_addr_q[0] : 32'h0, a & 32'hFFFF_FFE0);
            end
            if (rw) begin
                n_checks++; if (wdata_q.size() !== 8) begin n_fail++; $display("FAIL rnd%0d_wr_count got %0d want 8", it, wdata_q.size()); end
                for (int i = 0; i < 8 && i < wdata_q.size(); i++) begin
                    n_checks++; if (wdata_q[i] !== pl[32*i +: 32]) begin n_fail++; $display("FAIL rnd%0d_wr[%0d] got %h want %h", it, i, wdata_q[i], pl[32*i +: 32]); end
                end
            end else begin
                n_checks++; if (bus_rdData !== exp_rd) begin n_fail++; $display("FAIL rnd%0d_rd got %h want %h", it, bus_rdData, exp_rd); end
            end
            idle_cycles(1 + $urandom_range(0, 2));
        end
        for (int i = 0; i < 8; i++) wait_cfg[i] = 0;
    endtask

    task automatic test_go_held();
        int c0, d, dc0, d2;
        dc0 = done_cnt;
        start_and_wait(32'h2000_0040, 1'b0, '0, 1'b1, c0, d);
        n_checks++; if (d !== 10) begin n_fail++; $display("FAIL held_first_done got %0d want 10", d); end
        idle_cycles(1);   // cycle 11: idle samples the still-high go
        idle_cycles(1);   // cycle 12
        bus_go = 1'b0;
        n_checks++; if (O_htrans !== 2'b10) begin n_fail++; $display("FAIL held_second_start got %b want 10", O_htrans); end
        d2 = -1;
        for (int k = 0; k < 40; k++) begin
            if (bus_done === 1'b1) begin d2 = cyc - c0; break; end
            @(negedge clk); #1;
        end
        n_checks++; if (d2 !== 21) begin n_fail++; $display("FAIL held_second_done got %0d want 21", d2); end
        idle_cycles(4);
        n_checks++; if (acc_addr_q.size() !== 16) begin n_fail++; $display("FAIL held_addr_count got %0d want 16", acc_addr_q.size()); end
        if (acc_cyc_q.size() > 8) begin
            n_checks++; if (acc_trans_q[8] !== 2'b10 || acc_cyc_q[8] - c0 !== 12) begin n_fail++; $display("FAIL held_nonseq got %b@%0d want 10@12", acc_trans_q[8], acc_cyc_q[8] - c0); end
        end
        n_checks++; if (done_cnt - dc0 !== 2) begin n_fail++; $display("FAIL held_done_pulses got %0d want 2", done_cnt - dc0); end
    endtask

    task automatic test_error();
        logic [255:0] pl;
        int c0, d, dc0;
        for (int i = 0; i < 8; i++) pl[32*i +: 32] = $urandom;
        err_beat = 3; dc0 = done_cnt;
        start_and_wait(32'h3000_0000, 1'b1, pl, 1'b0, c0, d);
        n_checks++; if (d !== 7) begin n_fail++; $display("FAIL err_done_cycle got %0d want 7", d); end
        n_checks++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL err_flag got %b want 1", bus_err); end
        n_checks++; if (err_seen !== 1 || err_htrans !== 2'b00) begin n_fail++; $display("FAIL err_second_cycle_htrans got %b (seen %0d) want 00", err_htrans, err_seen); end
        idle_cycles(4);
        err_beat = -1;
        n_checks++; if (acc_addr_q.size() !== 4) begin n_fail++; $display("FAIL err_addr_count got %0d want 4", acc_addr_q.size()); end
        n_checks++; if (wdata_q.size() !== 3) begin n_fail++; $display("FAIL err_wr_count got %0d want 3", wdata_q.size()); end
        n_checks++; if (done_cnt - dc0 !== 1) begin n_fail++; $display("FAIL err_done_pulses got %0d want 1", done_cnt - dc0); end
        n_checks++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b want 1", bus_err); end
    endtask

    task automatic test_back_to_back();
        logic [255:0] exp_rd, pl;
        int c0, d;
        for (int i = 0; i < 8; i++) begin exp_rd[32*i +: 32] = 32'h11 * i; pl[32*i +: 32] = $urandom; end
        start_and_wait(32'h4000_0100, 1'b0, '0, 1'b0, c0, d);
        n_checks++; if (d !== 10) begin n_fail++; $display("FAIL b2b_read_done got %0d want 10", d); end
        n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL b2b_err_cleared got %b want 0", bus_err); end
        idle_cycles(3);
        n_checks++; if (bus_rdData !== exp_rd) begin n_fail++; $display("FAIL b2b_rd_retained got %h want %h", bus_rdData, exp_rd); end
        start_and_wait(32'h4000_0200, 1'b1, pl, 1'b0, c0, d);
        n_checks++; if (d !== 10) begin n_fail++; $display("FAIL b2b_write_done got %0d want 10", d); end
        n_checks++; if (wdata_q.size() !== 8 || wdata_q[7] !== pl[255:224]) begin n_fail++; $display("FAIL b2b_write_data got n=%0d want 8 ending %h", wdata_q.size(), pl[255:224]); end
        idle_cycles(2);
    endtask

    task automatic test_reset_mid();
        int dc0;
        burst_id++;
        bus_addr = 32'h5000_0000; bus_RW = 1'b1; bus_write = {8{32'hDEAD_BEEF}}; bus_go = 1'b1;
        idle_cycles(1);
        bus_go = 1'b0;
        idle_cycles(3);   // now in cycle 4 of the burst
        n_checks++; if (O_htrans !== 2'b11) begin n_fail++; $display("FAIL rstmid_in_burst got %b want 11", O_htrans); end
        dc0 = done_cnt;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({O_htrans, O_haddr, O_hwdata, O_hwrite, O_hburst, O_hsize, O_hprot, O_hnonsec, O_hmastlock, bus_done, bus_err} !== RST_VEC) begin
            n_fail++; $display("FAIL rstmid_async got %h want %h", {O_htrans, O_haddr, O_hwdata, O_hwrite, O_hburst, O_hsize, O_hprot, O_hnonsec, O_hmastlock, bus_done, bus_err}, RST_VEC);
        end
        idle_cycles(3);
        rst_n = 1'b1;
        idle_cycles(12);
        n_checks++; if (done_cnt - dc0 !== 0) begin n_fail++; $display("FAIL rstmid_no_done got %0d pulses want 0", done_cnt - dc0); end
        n_checks++; if (O_htrans !== 2'b00 || bus_rdData !== 256'h0) begin n_fail++; $display("FAIL rstmid_idle got htrans %b want 00", O_htrans); end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) wait_cfg[i] = 0;
        test_reset();
        test_write_zero_wait();
        test_read_waits();
        test_random();
        test_go_held();
        test_error();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
